// File: rtl/shift_seq_unit.sv
// Multi-cycle shifter for RV32I SLL/SRL/SRA: shifts up to STEP bits per cycle
// under a start/ready/done handshake. The pipeline stalls while busy is high.
module shift_seq_unit #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned STEP  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] operand,
    input  logic [4:0]       shamt,
    input  logic             flush,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int unsigned SHW = 5;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [1:0]       op_q, op_d;
    logic [SHW-1:0]   rem_q, rem_d;
    logic             ready_q, ready_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [SHW-1:0]   step_k;
    logic [WIDTH-1:0] shifted;

    // Bits consumed this cycle: min(STEP, remaining).
    always_comb begin
        step_k = rem_q;
        if (rem_q > SHW'(STEP)) begin
            step_k = SHW'(STEP);
        end
    end

    // One partial shift of the latched value; reserved op 11 behaves as SLL.
    always_comb begin
        shifted = sr_q << step_k;
        case (op_q)
            2'b01:   shifted = sr_q >> step_k;
            2'b10:   shifted = WIDTH'($signed(sr_q) >>> step_k);
            default: shifted = sr_q << step_k;
        endcase
    end

    // Next-state logic; flush wins over start so an aborted cycle never accepts.
    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        op_d    = op_q;
        rem_d   = rem_q;
        case (state_q)
            S_SHIFT: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    sr_d  = shifted;
                    rem_d = rem_q - step_k;
                    if (rem_q == step_k) begin
                        state_d = S_DONE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                if (!flush && start) begin
                    sr_d    = operand;
                    op_d    = op;
                    rem_d   = shamt;
                    state_d = (shamt != '0) ? S_SHIFT : S_DONE;
                end
            end
        endcase
        ready_d = (state_d != S_SHIFT);
        busy_d  = (state_d == S_SHIFT);
        done_d  = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            sr_q    <= '0;
            op_q    <= '0;
            rem_q   <= '0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            op_q    <= op_d;
            rem_q   <= rem_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign ready  = ready_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign result = sr_q;

endmodule

// File: doc/shift_seq_unit.md
Name: shift_seq_unit

Overview:
Multi-cycle shift execution unit for the RV32I shift instructions SLL/SRL/SRA and their immediate forms. It sequences a small per-cycle shifter under an FSM and replaces a full 32-bit barrel shifter in the execute stage. It uses a start/ready/done handshake with the pipeline control, which stalls while busy=1.

Parameters:
WIDTH, 32, data width in bits.
STEP, 1, maximum bits shifted per cycle. Legal values are 1, 2, 4 and 8.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst_n  input  1  asynchronous, active-low reset.
start  input  1  request; accepted only when ready=1.
op  input  2  shift type: 00 SLL, 01 SRL, 10 SRA, 11 reserved (treated as SLL).
operand  input  WIDTH  value to shift; sampled on acceptance.
shamt  input  5  shift amount 0..31; sampled on acceptance.
flush  input  1  synchronous abort of the current operation.
ready  output  1  unit can accept start this cycle.
busy  output  1  shifting in progress (state SHIFT).
done  output  1  one-cycle pulse; result valid.
result  output  WIDTH  shifted value; held stable until the next acceptance.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, result=0, remaining=0, done=0, busy=0, ready=1. Reset mid-operation discards the operation and produces no done.
- States:
  - IDLE: ready=1, busy=0, done=0.
  - SHIFT: ready=0, busy=1, done=0.
  - DONE: ready=1, busy=0, done=1.
- Acceptance: start=1 and ready=1 at an edge.
  - Latches the operand into the shift register (drives result), latches op, and sets remaining=shamt.
  - Next state is SHIFT if shamt!=0, otherwise DONE.
- SHIFT, each edge:
  - k = min(STEP, remaining).
  - Shift register shifts by k: SLL fills zeros at the LSB; SRL fills zeros at the MSB; SRA replicates the captured bit WIDTH-1.
  - remaining -= k. When the new remaining is 0, go to DONE.
- DONE lasts exactly one cycle.
  - With no new start, go to IDLE; result is held.
  - Start in DONE is accepted (back-to-back), same rules as in IDLE.
- Latency: with acceptance at edge 0, done=1 in cycle ceil(shamt/STEP)+1.
  - shamt=0 gives done in cycle 1 with result=operand.
  - STEP=1, shamt=31 gives done in cycle 32.
- Ignored start: start while busy=1 has no effect; the in-flight op, operand and remaining are unchanged.
- flush=1 at an edge: next state IDLE, no done pulse, result holds its current partial value.
  - flush has priority over start in the same cycle, so that start is not accepted.
- Inputs operand, op and shamt may change freely after acceptance; only the latched copies are used.
- Outputs are registered or decoded from the state register only; there is no combinational path from inputs to outputs.
- Shift amount is taken modulo 32 by construction (5-bit port). WIDTH other than 32 still uses the 5-bit shamt.

Test Plan:
- Reset then SLL, operand=32'h00000001, shamt=1 (STEP=1) -> busy in cycle 1, done=1 in cycle 2, result=32'h00000002, ready=1 in cycle 2.
- SRA, operand=32'haaaaffff, shamt=4 -> done in cycle 5, result=32'hfaaaafff. Same with SRL -> 32'h0aaaafff.
- SRL, 32'haaaaffff, shamt=31 -> done in cycle 32, result=32'h00000001. With STEP=4: done in cycle 9, same result. With STEP=8: done in cycle 5.
- shamt=0, any op, operand=32'h12345678 -> no busy cycle, done in cycle 1, result=32'h12345678. A start held high during DONE is accepted back-to-back.
- Start pulses while busy (second operand=32'hffffffff) -> ignored; first result correct, exactly one done.
- flush asserted in cycle 3 of a 10-bit shift -> IDLE in cycle 4, no done, ready=1. Separately, rst_n=0 mid-shift -> all outputs at reset values immediately, no done.
